// File: rtl/jtag_host.sv
// Bus-side JTAG master: runs TAP reset, IR and DR scans over TCK/TMS/TDI/TDO and
// always leaves the target TAP parked in Run-Test/Idle between commands.
module jtag_host #(
  parameter int MAX_LEN = 32,
  parameter int CLK_DIV = 2,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clock,
  input  logic               reset_bar,
  input  logic               start,
  input  logic [1:0]         cmd,
  input  logic [LW-1:0]      length,
  input  logic [MAX_LEN-1:0] tdi_data,
  output logic               busy,
  output logic               done,
  output logic [MAX_LEN-1:0] tdo_data,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST_SEQ, S_PRE, S_SHIFT, S_POST, S_FINISH
  } state_t;

  localparam int PW = $clog2(2 * CLK_DIV + 1);
  // Bit counter must reach both MAX_LEN-1 and 5 (the reset sequence).
  localparam int CW = (LW > 3) ? LW : 3;
  localparam logic [PW-1:0] PH_RISE = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_END  = PW'(2 * CLK_DIV - 1);

  state_t             state_q, state_d;
  logic [PW-1:0]      ph_q, ph_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LW-1:0]      len_q, len_d;
  logic               is_ir_q, is_ir_d;
  logic               scan_q, scan_d;
  logic               need_reset_q, need_reset_d;
  logic [MAX_LEN-1:0] tdi_buf_q, tdi_buf_d;
  logic [MAX_LEN-1:0] tdo_q, tdo_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               last_bit;
  logic               load_bit;
  logic [LW-1:0]      len_eff;

  assign len_eff  = (length > LW'(MAX_LEN)) ? LW'(MAX_LEN) : length;

  assign busy     = (state_q == S_RST_SEQ) || (state_q == S_PRE) ||
                    (state_q == S_SHIFT)   || (state_q == S_POST);
  assign done     = (state_q == S_FINISH);
  assign tdo_data = tdo_q;
  assign TCK      = tck_q;
  assign TMS      = tms_q;
  assign TDI      = tdi_q;

  always_comb begin
    last_bit = 1'b0;
    case (state_q)
      S_RST_SEQ: last_bit = (cnt_q == CW'(5));
      S_PRE:     last_bit = (cnt_q == (is_ir_q ? CW'(3) : CW'(2)));
      S_SHIFT:   last_bit = (cnt_q == CW'(len_q) - CW'(1));
      S_POST:    last_bit = (cnt_q == CW'(1));
      default:   last_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    is_ir_d      = is_ir_q;
    scan_d       = scan_q;
    need_reset_d = need_reset_q;
    tdi_buf_d    = tdi_buf_q;
    tdo_d        = tdo_q;
    tck_d        = tck_q;
    tms_d        = tms_q;
    tdi_d        = tdi_q;
    load_bit     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((cmd == 2'b11) || ((cmd != 2'b00) && (len_eff == '0))) begin
            state_d = S_FINISH;
          end else begin
            len_d     = len_eff;
            is_ir_d   = (cmd == 2'b01);
            scan_d    = (cmd != 2'b00);
            tdi_buf_d = tdi_data;
            if (cmd != 2'b00) tdo_d = '0;
            state_d   = ((cmd == 2'b00) || need_reset_q) ? S_RST_SEQ : S_PRE;
            cnt_d     = '0;
            load_bit  = 1'b1;
          end
        end
      end
      S_RST_SEQ, S_PRE, S_SHIFT, S_POST: begin
        if (ph_q == PH_RISE) begin
          // TDO is captured on the clock TCK rises, i.e. the value held before the edge.
          tck_d = 1'b1;
          ph_d  = ph_q + PW'(1);
          if (state_q == S_SHIFT) begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (cnt_q == CW'(i)) tdo_d[i] = TDO;
            end
          end
        end else if (ph_q == PH_END) begin
          tck_d = 1'b0;
          ph_d  = '0;
          if (!last_bit) begin
            cnt_d    = cnt_q + CW'(1);
            load_bit = 1'b1;
          end else begin
            cnt_d = '0;
            case (state_q)
              S_RST_SEQ: begin
                need_reset_d = 1'b0;
                if (scan_q) begin
                  state_d  = S_PRE;
                  load_bit = 1'b1;
                end else begin
                  state_d = S_FINISH;
                end
              end
              S_PRE: begin
                state_d  = S_SHIFT;
                load_bit = 1'b1;
              end
              S_SHIFT: begin
                state_d  = S_POST;
                load_bit = 1'b1;
              end
              default: state_d = S_FINISH;
            endcase
          end
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Pins change only at the start of a low phase, driven from the bit about to run.
    if (load_bit) begin
      tck_d = 1'b0;
      ph_d  = '0;
      tdi_d = 1'b0;
      case (state_d)
        S_RST_SEQ: tms_d = (cnt_d != CW'(5));
        S_PRE:     tms_d = is_ir_d ? (cnt_d < CW'(2)) : (cnt_d == '0);
        S_SHIFT: begin
          tms_d = (cnt_d == CW'(len_d) - CW'(1));
          for (int i = 0; i < MAX_LEN; i++) begin
            if (cnt_d == CW'(i)) tdi_d = tdi_buf_d[i];
          end
        end
        S_POST:    tms_d = (cnt_d == '0);
        default:   tms_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_bar) begin
      state_q      <= S_IDLE;
      ph_q         <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      is_ir_q      <= 1'b0;
      scan_q       <= 1'b0;
      need_reset_q <= 1'b1;
      tdi_buf_q    <= '0;
      tdo_q        <= '0;
      tck_q        <= 1'b0;
      tms_q        <= 1'b1;
      tdi_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      is_ir_q      <= is_ir_d;
      scan_q       <= scan_d;
      need_reset_q <= need_reset_d;
      tdi_buf_q    <= tdi_buf_d;
      tdo_q        <= tdo_d;
      tck_q        <= tck_d;
      tms_q        <= tms_d;
      tdi_q        <= tdi_d;
    end
  end

endmodule

// File: tb/tb_jtag_host.sv
// Bench for jtag_host: a behavioural TAP target (3-bit IR, bypass, 32-bit ID register)
// plus a command-level reference model for TMS streams, timing and captured TDO data.
module tb_jtag_host;
  localparam int MAX_LEN = 32;
  localparam int CLK_DIV = 2;
  localparam int LW      = 6;
  localparam logic [31:0] ID = 32'hCAFE_0001;

  logic          clock = 1'b0;
  logic          reset_bar = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    cmd = 2'b00;
  logic [LW-1:0] length = '0;
  logic [31:0]   tdi_data = '0;
  logic          busy, done;
  logic [31:0]   tdo_data;
  logic          TCK, TMS, TDI;
  logic          TDO = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  jtag_host #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV)) dut (
    .clock(clock), .reset_bar(reset_bar), .start(start), .cmd(cmd), .length(length),
    .tdi_data(tdi_data), .busy(busy), .done(done), .tdo_data(tdo_data),
    .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  // ---------------- target TAP ----------------
  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
  } tap_t;

  tap_t        tap_st = TLR;
  logic [31:0] tap_sr = '0;
  int          tap_len = 1;
  logic [2:0]  tap_ir = 3'b100;
  bit          got_tms[$];
  bit          got_tdi[$];

  function automatic tap_t tap_next(tap_t s, logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PADR;
      PADR:  return m ? EX2DR : PADR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PAIR;
      PAIR:  return m ? EX2IR : PAIR;
      EX2IR: return m ? UPIR  : SHIR;
      UPIR:  return m ? SELDR : RTI;
      default: return TLR;
    endcase
  endfunction

  always @(posedge TCK) begin
    got_tms.push_back(TMS);
    got_tdi.push_back(TDI);
    case (tap_st)
      TLR:   tap_ir = 3'b100;
      CAPIR: begin tap_sr = 32'h1; tap_len = 3; end
      CAPDR: if (tap_ir == 3'b111) begin tap_sr = '0; tap_len = 1; end
             else begin tap_sr = ID; tap_len = 32; end
      SHIR, SHDR: tap_sr = (tap_sr >> 1) | ({31'b0, TDI} << (tap_len - 1));
      UPIR:  tap_ir = tap_sr[2:0];
      default: ;
    endcase
    tap_st = tap_next(tap_st, TMS);
  end

  always @(negedge TCK) if (tap_st == SHIR || tap_st == SHDR) TDO = tap_sr[0];

  // ---------------- reference model ----------------
  bit         m_need = 1'b1;
  logic [2:0] m_ir = 3'b100;
  logic [31:0] m_tdo = '0;
  bit         exp_tms[$];

  // Scan = capture value of the selected register followed by the shifted-in data.
  task automatic model_cmd(input logic [1:0] c, input int len_in, input logic [31:0] d,
                           output int e_tck, output logic [31:0] e_tdo,
                           output int shift_at, output int L);
    logic [63:0] cat, mask, cap;
    int n;
    L = (len_in > MAX_LEN) ? MAX_LEN : len_in;
    exp_tms.delete();
    shift_at = 0;
    e_tdo = m_tdo;
    if (c == 2'b11 || (c != 2'b00 && L == 0)) begin
      L = 0;
    end else begin
      if (c == 2'b00 || m_need) begin
        repeat (5) exp_tms.push_back(1'b1);
        exp_tms.push_back(1'b0);
        m_need = 1'b0;
        m_ir = 3'b100;
      end
      if (c == 2'b00) begin
        L = 0;
      end else begin
        if (c == 2'b01) begin
          exp_tms.push_back(1'b1); exp_tms.push_back(1'b1);
          exp_tms.push_back(1'b0); exp_tms.push_back(1'b0);
          n = 3; cap = 64'h1;
        end else begin
          exp_tms.push_back(1'b1); exp_tms.push_back(1'b0); exp_tms.push_back(1'b0);
          if (m_ir == 3'b111) begin n = 1; cap = 64'h0; end
          else begin n = 32; cap = {32'b0, ID}; end
        end
        shift_at = exp_tms.size();
        for (int i = 0; i < L; i++) exp_tms.push_back(i == L - 1);
        exp_tms.push_back(1'b1); exp_tms.push_back(1'b0);
        mask  = (64'd1 << L) - 64'd1;
        cat   = (({32'b0, d} & mask) << n) | cap;
        e_tdo = cat[31:0] & mask[31:0];
        if (c == 2'b01) m_ir = 3'(cat >> L);
        m_tdo = e_tdo;
      end
    end
    e_tck = exp_tms.size();
  endtask

  task automatic check(input string nm, input string what, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s actual=%0h required=%0h", nm, what, got, exp);
    end
  endtask

  task automatic run_cmd(input string nm, input logic [1:0] c, input int len_in, input logic [31:0] d,
                         input bit use_tbl, input int t_tck, input logic [31:0] t_tdo, input int poke_at);
    int e_tck, shift_at, L, base, n;
    logic [31:0] e_tdo;
    bit gap, seq_ok, tdi_ok;
    model_cmd(c, len_in, d, e_tck, e_tdo, shift_at, L);
    if (use_tbl) begin e_tck = t_tck; e_tdo = t_tdo; end
    base = got_tms.size();
    @(negedge clock);
    start = 1'b1; cmd = c; length = LW'(len_in); tdi_data = d;
    @(negedge clock);
    start = 1'b0; cmd = 2'($urandom); length = LW'($urandom); tdi_data = $urandom;
    n = 0; gap = 1'b0;
    while (!done && n < 2000) begin
      if (!busy) gap = 1'b1;
      n++;
      start = (n == poke_at);
      if (n == poke_at) cmd = 2'b00;
      @(negedge clock);
    end
    start = 1'b0;
    check(nm, "busy_cycles", n, e_tck * 2 * CLK_DIV);
    check(nm, "busy_gap", gap, 0);
    check(nm, "busy_at_done", busy, 0);
    check(nm, "tck_at_done", TCK, 0);
    if (e_tck > 0) check(nm, "tms_parked", TMS, 0);
    check(nm, "tck_rises", got_tms.size() - base, e_tck);
    seq_ok = (got_tms.size() - base == exp_tms.size());
    if (seq_ok) for (int i = 0; i < exp_tms.size(); i++) if (got_tms[base + i] != exp_tms[i]) seq_ok = 1'b0;
    check(nm, "tms_seq", seq_ok, 1);
    if (L > 0 && got_tdi.size() >= base + shift_at + L) begin
      tdi_ok = 1'b1;
      for (int i = 0; i < L; i++) if (got_tdi[base + shift_at + i] != d[i]) tdi_ok = 1'b0;
      check(nm, "tdi_bits", tdi_ok, 1);
    end
    check(nm, "tdo_data", tdo_data, e_tdo);
    if (e_tck > 0) check(nm, "tap_in_rti", 64'(tap_st), 64'(RTI));
    @(negedge clock);
    check(nm, "done_width", done, 0);
    $display("%s cmd=%0d len=%0d tdi=%h tck=%0d/%0d tdo=%h/%h", nm, c, len_in, d,
             got_tms.size() - base, e_tck, tdo_data, e_tdo);
  endtask

  typedef struct {
    logic [1:0]  c;
    int          len;
    logic [31:0] d;
    int          tck;
    logic [31:0] tdo;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int n, base;
    bit seen_done;

    tbl[0] = '{c:2'b00, len:0,  d:32'h0,         tck:6,  tdo:32'h0};
    tbl[1] = '{c:2'b01, len:3,  d:32'h2,         tck:9,  tdo:32'h1};
    tbl[2] = '{c:2'b01, len:3,  d:32'h7,         tck:9,  tdo:32'h1};
    tbl[3] = '{c:2'b10, len:8,  d:32'hA5,        tck:13, tdo:32'h4A};
    tbl[4] = '{c:2'b10, len:0,  d:32'hFF,        tck:0,  tdo:32'h4A};
    tbl[5] = '{c:2'b10, len:40, d:32'h8000_0001, tck:37, tdo:32'h2};
    tbl[6] = '{c:2'b01, len:5,  d:32'h16,        tck:11, tdo:32'h11};
    tbl[7] = '{c:2'b10, len:32, d:32'h0,         tck:37, tdo:32'hCAFE_0001};
    tbl[8] = '{c:2'b11, len:7,  d:32'h5,         tck:0,  tdo:32'hCAFE_0001};
    tbl[9] = '{c:2'b01, len:1,  d:32'h1,         tck:7,  tdo:32'h1};

    repeat (3) @(negedge clock);
    check("reset", "TCK", TCK, 0);
    check("reset", "TMS", TMS, 1);
    check("reset", "TDI", TDI, 0);
    check("reset", "busy", busy, 0);
    check("reset", "done", done, 0);
    check("reset", "tdo_data", tdo_data, 0);
    reset_bar = 1'b1;

    for (int i = 0; i < 10; i++)
      run_cmd("tbl", tbl[i].c, tbl[i].len, tbl[i].d, 1'b1, tbl[i].tck, tbl[i].tdo, -1);

    // A start while busy must not disturb the scan in progress.
    run_cmd("poke", 2'b10, 12, $urandom, 1'b0, 0, 32'h0, 10);

    // Start held through the done clock is rejected; busy must stay low.
    @(negedge clock);
    start = 1'b1; cmd = 2'b11;
    @(negedge clock);
    check("b2b", "noop_done", done, 1);
    check("b2b", "noop_busy", busy, 0);
    cmd = 2'b10; length = 6'd4;
    @(negedge clock);
    check("b2b", "reject_busy", busy, 0);
    check("b2b", "reject_done", done, 0);
    start = 1'b0;
    $display("b2b start during done rejected busy=%0d", busy);
    run_cmd("b2b", 2'b10, 4, $urandom, 1'b0, 0, 32'h0, -1);

    // Reset in the middle of shift bit 5 of a DR scan.
    base = got_tms.size();
    @(negedge clock);
    start = 1'b1; cmd = 2'b10; length = 6'd16; tdi_data = $urandom;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (got_tms.size() - base < 9 && n < 500) begin @(negedge clock); n++; end
    check("abort", "reached_bit5", n < 500, 1);
    reset_bar = 1'b0;
    @(negedge clock);
    check("abort", "TCK", TCK, 0);
    check("abort", "TMS", TMS, 1);
    check("abort", "busy", busy, 0);
    check("abort", "done", done, 0);
    check("abort", "tdo_data", tdo_data, 0);
    reset_bar = 1'b1;
    seen_done = 1'b0;
    repeat (20) begin @(negedge clock); if (done) seen_done = 1'b1; end
    check("abort", "no_done", seen_done, 0);
    $display("abort reset at shift bit 5 busy=%0d TMS=%0d", busy, TMS);
    m_need = 1'b1;
    m_tdo  = '0;
    run_cmd("after_abort", 2'b10, 8, $urandom, 1'b0, 0, 32'h0, -1);

    for (int i = 0; i < 25; i++)
      run_cmd("rnd", 2'($urandom_range(0, 3)), $urandom_range(0, 40), $urandom, 1'b0, 0, 32'h0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
